// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the R-type encoder: opcode/func fields, ALU-control codes
// (mirroring the common ALU-control defines) and the encoder FSM state type.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] FUNC7_BASE = 7'h00;
  localparam logic [6:0] FUNC7_ALT  = 7'h20;

  localparam logic [2:0] FUNC3_ADD_SUB = 3'h0;
  localparam logic [2:0] FUNC3_SLL     = 3'h1;
  localparam logic [2:0] FUNC3_SLT     = 3'h2;
  localparam logic [2:0] FUNC3_SLTU    = 3'h3;
  localparam logic [2:0] FUNC3_XOR     = 3'h4;
  localparam logic [2:0] FUNC3_SRL_SRA = 3'h5;
  localparam logic [2:0] FUNC3_OR      = 3'h6;
  localparam logic [2:0] FUNC3_AND     = 3'h7;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_RUN,
    ENC_DRAIN,
    ENC_DONE
  } enc_state_e;

  function automatic logic alu_is_rtype(input logic [4:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/enc_word_fifo.sv
// Synchronous FIFO holding encoded instruction words; head is read straight from
// registered storage so a word pushed in cycle N is visible in cycle N+1.
module enc_word_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_inst_encoder.sv
// Packs {alu_control, rs1, rs2, rd} tuples into RV32I R-type words and streams them into IMEM.
// Optional illegal-op detection and counting is enabled by defining RTYPE_ENC_CHECK_EN.
module reg_inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_inst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_control,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  output logic              imem_wr_valid,
  input  logic              imem_wr_ready,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt
);

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q, acc_q;
  logic              done_q;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop, tuple_legal;
  logic [31:0]       enc_word, fifo_head;

  // Unknown codes fall through to the ADD encoding.
  function automatic logic [31:0] encode_rtype(input logic [4:0] op, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [4:0] rd);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = FUNC3_ADD_SUB;
    f7 = FUNC7_BASE;
    case (op)
      ALU_SUB:  f7 = FUNC7_ALT;
      ALU_SLL:  f3 = FUNC3_SLL;
      ALU_SLT:  f3 = FUNC3_SLT;
      ALU_SLTU: f3 = FUNC3_SLTU;
      ALU_XOR:  f3 = FUNC3_XOR;
      ALU_SRL:  f3 = FUNC3_SRL_SRA;
      ALU_SRA: begin
        f3 = FUNC3_SRL_SRA;
        f7 = FUNC7_ALT;
      end
      ALU_OR:   f3 = FUNC3_OR;
      ALU_AND:  f3 = FUNC3_AND;
      default:  ;
    endcase
    return {f7, rs2, rs1, f3, rd, OPCODE_OP};
  endfunction

  assign enc_word      = encode_rtype(in_alu_control, in_rs1, in_rs2, in_rd);
  assign in_ready      = (state_q == ENC_RUN) && !fifo_full;
  assign accept        = in_valid && in_ready;
  assign push          = accept && tuple_legal;
  assign imem_wr_valid = !fifo_empty;
  assign pop           = imem_wr_valid && imem_wr_ready;
  assign imem_wr_addr  = addr_q;
  assign imem_wr_data  = fifo_head;
  assign busy          = (state_q != ENC_IDLE);
  assign done          = done_q;

  enc_word_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (enc_word),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef RTYPE_ENC_CHECK_EN
  logic [CNT_W-1:0] err_q;

  assign tuple_legal = alu_is_rtype(in_alu_control);
  assign err_cnt     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if ((state_q == ENC_IDLE) && start) begin
      err_q <= '0;
    end else if (accept && !tuple_legal && (err_q != '1)) begin
      err_q <= err_q + CNT_W'(1);
    end
  end
`else
  assign tuple_legal = 1'b1;
  assign err_cnt     = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENC_IDLE;
      addr_q  <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) addr_q <= addr_q + ADDR_W'(4);
      case (state_q)
        ENC_IDLE: begin
          if (start) begin
            addr_q <= base_addr & ~ADDR_W'(3);
            num_q  <= num_inst;
            acc_q  <= '0;
            if (num_inst == '0) begin
              state_q <= ENC_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ENC_RUN;
            end
          end
        end
        ENC_RUN: begin
          if (accept) begin
            acc_q <= acc_q + CNT_W'(1);
            if ((acc_q + CNT_W'(1)) == num_q) state_q <= ENC_DRAIN;
          end
        end
        ENC_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ENC_DONE;
            done_q  <= 1'b1;
          end
        end
        ENC_DONE: state_q <= ENC_IDLE;
        default:  state_q <= ENC_IDLE;
      endcase
    end
  end

endmodule
